// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Purpose:
//   Brings up the board PLL from the 25 MHz reference domain. It holds the
//   PLL in reset, waits for LOCK, qualifies LOCK over a stable window and only
//   then releases a clean synchronous system reset downstream. In the running
//   state it accepts new phase (PSDA) and duty (DUTYDA) codes through a
//   valid/ready handshake, then blocks further changes for a settle window.
//   Any loss of lock after the first qualification restarts the whole sequence
//   and bumps a saturating re-lock counter.
//
// Optional feature (compile-time macro PLLSEQ_LOCK_TIMEOUT_EN):
//   Defined   : WAIT_LOCK gives up after LOCK_TIMEOUT cycles, re-resets the PLL
//               and counts the attempt in relock_cnt.
//   Undefined : WAIT_LOCK waits for lock indefinitely.
//
// Ports:
//   clkin       in   reference clock, all logic on the rising edge
//   reset       in   synchronous active-high reset
//   pll_lock    in   raw asynchronous PLL LOCK
//   pll_reset   out  PLL RESET
//   pll_psda    out  PLL dynamic phase code
//   pll_dutyda  out  PLL dynamic duty code
//   sys_rst     out  synchronous active-high reset for downstream logic
//   locked      out  qualified lock status
//   cfg_valid   in   configuration request
//   cfg_ready   out  configuration accept (high only while running)
//   cfg_psda    in   requested phase code
//   cfg_dutyda  in   requested duty code
//   relock_cnt  out  saturating count of re-lock attempts
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter logic [3:0]  PSDA_INIT     = 4'b0000,
    parameter logic [3:0]  DUTYDA_INIT   = 4'b1000
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    output logic       sys_rst,
    output logic       locked,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic [7:0] relock_cnt
);

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        CFG_SETTLE
    } state_e;

    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lock_meta_q, lock_s_q;
    logic [3:0]  psda_q, psda_d;
    logic [3:0]  dutyda_q, dutyda_d;
    logic [7:0]  relock_q, relock_d;
    logic        pll_reset_q, pll_reset_d;
    logic        sys_rst_q, sys_rst_d;
    logic        locked_q, locked_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        relock_evt;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // variable unassigned; that is what keeps this block latch-free.
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        psda_d     = psda_q;
        dutyda_d   = dutyda_q;
        relock_evt = 1'b0;

        unique case (state_q)
            RESET_HOLD: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = STABLE;
                end
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = RESET_HOLD;
                    relock_evt = 1'b1;
                end
`else
                // No retry: park the counter instead of letting it wrap.
                else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = cnt_q;
                end
`endif
            end
            STABLE: begin
                // A dropout restarts qualification but is not a re-lock.
                if (!lock_s_q)                  state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = RUN;
            end
            RUN: begin
                // Lock loss outranks a pending configuration request.
                if (!lock_s_q) begin
                    state_d    = RESET_HOLD;
                    relock_evt = 1'b1;
                end else if (cfg_valid && cfg_ready_q) begin
                    state_d  = CFG_SETTLE;
                    psda_d   = cfg_psda;
                    dutyda_d = cfg_dutyda;
                end
            end
            CFG_SETTLE: begin
                if (!lock_s_q) begin
                    state_d    = RESET_HOLD;
                    relock_evt = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                end
            end
            default: state_d = RESET_HOLD;
        endcase

        if (state_d != state_q) cnt_d = '0;

        relock_d = (relock_evt && relock_q != 8'hFF) ? relock_q + 8'd1 : relock_q;

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state and never glitch.
        pll_reset_d = (state_d == RESET_HOLD);
        sys_rst_d   = (state_d inside {RESET_HOLD, WAIT_LOCK, STABLE});
        locked_d    = (state_d inside {RUN, CFG_SETTLE});
        cfg_ready_d = (state_d == RUN);
    end

    always_ff @(posedge clkin) begin
        // NOTE: non-blocking assignments for all state so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= RESET_HOLD;
            cnt_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            psda_q      <= PSDA_INIT;
            dutyda_q    <= DUTYDA_INIT;
            relock_q    <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            psda_q      <= psda_d;
            dutyda_q    <= dutyda_d;
            relock_q    <= relock_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_q   <= sys_rst_d;
            locked_q    <= locked_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_psda   = psda_q;
    assign pll_dutyda = dutyda_q;
    assign sys_rst    = sys_rst_q;
    assign locked     = locked_q;
    assign cfg_ready  = cfg_ready_q;
    assign relock_cnt = relock_q;

endmodule
